// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Shared constants for the load/store control unit: instruction
//           field positions, opcodes, ALU codes, FSM state encodings and the
//           instruction class latched at decode.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Instruction field slice positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int C_MSB   = 18;
    localparam int C_LSB   = 0;

    // Opcodes handled by this control unit
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation codes
    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00011;

    // FSM state encodings; values 10..15 are illegal and recover to S_RST
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // Instruction class captured at decode, steers T5..T7
    typedef enum logic [1:0] {
        K_LD  = 2'd0,
        K_LDI = 2'd1,
        K_ST  = 2'd2
    } kind_t;

    // States that perform a memory access and may be stretched by the
    // wait counter: fetch read (T1), ld read (T6), st write (T7).
    function automatic logic is_mem_state(input state_t s, input kind_t k);
        return (s == S_T1) || ((s == S_T6) && (k == K_LD)) ||
               ((s == S_T7) && (k == K_ST));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_counter
// Brief   : Down-counter that stretches memory-access states. Loaded with
//           LOAD_VAL on entry to a memory state, decremented each cycle the
//           FSM waits, saturates at zero.
// Ports   : clk     - clock
//           rst     - synchronous active-high reset (count to zero)
//           i_load  - load LOAD_VAL (priority over i_dec)
//           i_dec   - decrement by one when non-zero
//           o_zero  - count is zero, the access may complete
// Revision: 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
    parameter int CNT_W    = 4,
    parameter int LOAD_VAL = 0     // must fit in CNT_W bits
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(LOAD_VAL);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ldst_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : ldst_control_unit
// Brief   : Hardwired Moore control FSM for the data path. Sequences the
//           instruction fetch (T0-T2), decodes the opcode in T3 and runs the
//           execute steps of ld / ldi / st. HALT parks the unit until clear.
//           Memory states can be stretched by MEM_WAIT extra cycles.
// Ports   : Clock      - clock, all state changes on rising edge
//           clear      - synchronous active-high reset
//           ir[31:0]   - instruction register contents (opcode in [31:27])
//           PCout, Zlowout, MDRout, Cout, Rout, BAOut - bus drive selects
//           PCin, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, Rin, IncPC
//                      - register load enables
//           Gra, Grb, Grc, Read, Write - register select and memory strobes
//           op[4:0]    - ALU operation (ADD in T4 of ld/ldi/st)
//           run        - 1 while sequencing, 0 in HALT
//           illegal    - pulses in T3 for an unsupported opcode
//           state_dbg  - current state encoding
// Revision: 1.0 - initial release
// ============================================================================
module ldst_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,    // 0..15
    parameter int CNT_W    = 4     // must hold MEM_WAIT
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        Rout,
    output logic        BAOut,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZHighin,
    output logic        Zlowin,
    output logic        Rin,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  op,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  state_dbg
);

    state_t     r_state;
    state_t     w_next;
    kind_t      r_kind;
    kind_t      w_kind_next;
    logic [4:0] w_opc;
    logic       w_opc_illegal;
    logic       w_in_mem;
    logic       w_adv;
    logic       w_cnt_zero;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_unused_ir;

    assign w_opc         = ir[OPC_MSB:OPC_LSB];
    assign w_opc_illegal = (w_opc != OP_LD) && (w_opc != OP_LDI) &&
                           (w_opc != OP_ST) && (w_opc != OP_HALT);
    // Register and constant fields are consumed by the data path, not here.
    assign w_unused_ir   = ^{ir[RA_MSB:RA_LSB], ir[RB_MSB:RB_LSB], ir[C_MSB:C_LSB]};

    // A memory state advances only once its wait count has drained;
    // non-memory states always advance.
    assign w_in_mem   = is_mem_state(r_state, r_kind);
    assign w_adv      = !w_in_mem || w_cnt_zero;
    // Load on entry into a memory state, count down while holding in one.
    assign w_cnt_load = is_mem_state(w_next, w_kind_next) && (w_next != r_state);
    assign w_cnt_dec  = w_in_mem && !w_cnt_zero;

    mem_wait_counter #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (MEM_WAIT)
    ) u_wait (
        .clk    (Clock),
        .rst    (clear),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state <= S_RST;
            r_kind  <= K_LD;
        end else begin
            r_state <= w_next;
            r_kind  <= w_kind_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; ir is only looked at in T3
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_kind_next = r_kind;
        case (r_state)
            S_RST:  w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   if (w_adv) w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3: begin
                case (w_opc)
                    OP_LD: begin
                        w_next      = S_T4;
                        w_kind_next = K_LD;
                    end
                    OP_LDI: begin
                        w_next      = S_T4;
                        w_kind_next = K_LDI;
                    end
                    OP_ST: begin
                        w_next      = S_T4;
                        w_kind_next = K_ST;
                    end
                    OP_HALT: w_next = S_HALT;
                    default: w_next = S_T0;   // unsupported opcode acts as NOP
                endcase
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = (r_kind == K_LDI) ? S_T0 : S_T6;
            S_T6:   if (w_adv) w_next = S_T7;
            S_T7:   if (w_adv) w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode. T3 strobes are issued for every opcode since
    // they depend on state only; only the illegal flag looks at ir.
    // ------------------------------------------------------------------
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        Rout    = 1'b0;
        BAOut   = 1'b0;
        PCin    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        ZHighin = 1'b0;
        Zlowin  = 1'b0;
        Rin     = 1'b0;
        IncPC   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        op      = ALU_NOP;
        run     = 1'b1;
        illegal = 1'b0;
        case (r_state)
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZHighin = 1'b1;
                Zlowin  = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
            end
            S_T3: begin
                Grb     = 1'b1;
                BAOut   = 1'b1;
                Yin     = 1'b1;
                illegal = w_opc_illegal;
            end
            S_T4: begin
                Cout    = 1'b1;
                ZHighin = 1'b1;
                Zlowin  = 1'b1;
                op      = ALU_ADD;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (r_kind == K_LDI) begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (r_kind == K_ST) begin
                    Gra  = 1'b1;      // MDR captures Ra from the bus
                    Rout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                if (r_kind == K_ST) begin
                    Write = 1'b1;
                end else begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end
            end
            S_HALT: run = 1'b0;
            default: ;
        endcase
    end

    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ldst_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ldst_control_unit
// Brief   : Self-checking bench for ldst_control_unit. Two instances run in
//           parallel (MEM_WAIT=0 and MEM_WAIT=2) from shared stimulus. Each has
//           a sequence model: a queue of expected per-cycle output vectors
//           built from the instruction step lists, compared every cycle.
//           Literal checks pin instruction lengths and strobe counts.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ldst_control_unit;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] ir;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // strobe bit positions in the packed vector
    localparam logic [19:0] M_PCOUT   = 20'd1 << 0;
    localparam logic [19:0] M_ZLOWOUT = 20'd1 << 1;
    localparam logic [19:0] M_MDROUT  = 20'd1 << 2;
    localparam logic [19:0] M_COUT    = 20'd1 << 3;
    localparam logic [19:0] M_ROUT    = 20'd1 << 4;
    localparam logic [19:0] M_BAOUT   = 20'd1 << 5;
    localparam logic [19:0] M_PCIN    = 20'd1 << 6;
    localparam logic [19:0] M_MARIN   = 20'd1 << 7;
    localparam logic [19:0] M_MDRIN   = 20'd1 << 8;
    localparam logic [19:0] M_IRIN    = 20'd1 << 9;
    localparam logic [19:0] M_YIN     = 20'd1 << 10;
    localparam logic [19:0] M_ZHIGHIN = 20'd1 << 11;
    localparam logic [19:0] M_ZLOWIN  = 20'd1 << 12;
    localparam logic [19:0] M_RIN     = 20'd1 << 13;
    localparam logic [19:0] M_INCPC   = 20'd1 << 14;
    localparam logic [19:0] M_GRA     = 20'd1 << 15;
    localparam logic [19:0] M_GRB     = 20'd1 << 16;
    localparam logic [19:0] M_GRC     = 20'd1 << 17;
    localparam logic [19:0] M_READ    = 20'd1 << 18;
    localparam logic [19:0] M_WRITE   = 20'd1 << 19;

    localparam logic [31:0] IR_LD   = 32'h0100_0095;
    localparam logic [31:0] IR_LDI  = 32'h0810_0038;
    localparam logic [31:0] IR_ST   = 32'h1180_0087;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_BAD  = 32'h3800_0000;

    typedef struct packed {
        logic [3:0]  st;
        logic [19:0] mask;
        logic [4:0]  op;
        logic        run;
        logic        dec;
    } exp_t;

    function automatic exp_t mk(input logic [3:0] st, input logic [19:0] m);
        exp_t t;
        t.st   = st;
        t.mask = m;
        t.op   = ALU_NOP;
        t.run  = 1'b1;
        t.dec  = 1'b0;
        return t;
    endfunction

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int W = 2 * g;

        logic       PCout, Zlowout, MDRout, Cout, Rout, BAOut;
        logic       PCin, MARin, MDRin, IRin, Yin, ZHighin, Zlowin, Rin, IncPC;
        logic       Gra, Grb, Grc, Read, Write;
        logic [4:0] op;
        logic       run, illegal;
        logic [3:0] state_dbg;
        logic [19:0] strobes;

        assign strobes = {Write, Read, Grc, Grb, Gra, IncPC, Rin, Zlowin, ZHighin,
                          Yin, IRin, MDRin, MARin, PCin, BAOut, Rout, Cout, MDRout,
                          Zlowout, PCout};

        ldst_control_unit #(.MEM_WAIT(W), .CNT_W(4)) u_dut (
            .Clock(clk), .clear(clear), .ir(ir),
            .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
            .Rout(Rout), .BAOut(BAOut), .PCin(PCin), .MARin(MARin),
            .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZHighin(ZHighin),
            .Zlowin(Zlowin), .Rin(Rin), .IncPC(IncPC), .Gra(Gra), .Grb(Grb),
            .Grc(Grc), .Read(Read), .Write(Write), .op(op), .run(run),
            .illegal(illegal), .state_dbg(state_dbg)
        );

        exp_t q[$];
        exp_t cur;
        bit   valid  = 1'b0;
        bit   halted = 1'b0;

        // per-instruction measurements (T0 to next T0)
        bit   started = 1'b0;
        int   len, rd, wr, add_cnt, ill, mdrin;
        int   last_len = -1, last_rd = -1, last_wr = -1, last_add = -1;
        int   last_ill = -1, last_mdrin = -1;

        // Model advance at the active edge
        initial begin : p_model
            exp_t t;
            forever begin
                @(posedge clk);
                if (clear) begin
                    q.delete();
                    halted = 1'b0;
                    cur    = mk(S_RST, '0);
                    valid  = 1'b1;
                end else if (valid) begin
                    if (q.size() == 0) begin
                        if (halted) begin
                            t = mk(S_HALT, '0);
                            t.run = 1'b0;
                            q.push_back(t);
                        end else begin
                            q.push_back(mk(S_T0, M_PCOUT | M_MARIN | M_INCPC | M_ZHIGHIN | M_ZLOWIN));
                            for (int i = 0; i <= W; i++)
                                q.push_back(mk(S_T1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN));
                            q.push_back(mk(S_T2, M_MDROUT | M_IRIN));
                            t = mk(S_T3, M_GRB | M_BAOUT | M_YIN);
                            t.dec = 1'b1;
                            q.push_back(t);
                        end
                    end
                    cur = q.pop_front();
                end
            end
        end

        // Compare and measure away from the active edge
        initial begin : p_compare
            logic       exp_ill;
            logic [4:0] opc;
            exp_t       t;
            forever begin
                @(negedge clk);
                if (valid) begin
                    exp_ill = 1'b0;
                    if (cur.dec) begin
                        opc = ir[31:27];
                        exp_ill = !((opc == OP_LD) || (opc == OP_LDI) ||
                                    (opc == OP_ST) || (opc == OP_HALT));
                        if ((opc == OP_LD) || (opc == OP_LDI) || (opc == OP_ST)) begin
                            t = mk(S_T4, M_COUT | M_ZHIGHIN | M_ZLOWIN);
                            t.op = ALU_ADD;
                            q.push_back(t);
                        end
                        if (opc == OP_LD) begin
                            q.push_back(mk(S_T5, M_ZLOWOUT | M_MARIN));
                            for (int i = 0; i <= W; i++)
                                q.push_back(mk(S_T6, M_READ | M_MDRIN));
                            q.push_back(mk(S_T7, M_MDROUT | M_GRA | M_RIN));
                        end else if (opc == OP_LDI) begin
                            q.push_back(mk(S_T5, M_ZLOWOUT | M_GRA | M_RIN));
                        end else if (opc == OP_ST) begin
                            q.push_back(mk(S_T5, M_ZLOWOUT | M_MARIN));
                            q.push_back(mk(S_T6, M_GRA | M_ROUT | M_MDRIN));
                            for (int i = 0; i <= W; i++)
                                q.push_back(mk(S_T7, M_WRITE));
                        end else if (opc == OP_HALT) begin
                            halted = 1'b1;
                        end
                    end
                    checks++;
                    if ((state_dbg !== cur.st) || (strobes !== cur.mask) ||
                        (op !== cur.op) || (run !== cur.run) || (illegal !== exp_ill)) begin
                        errors++;
                        $display("FAIL model_cmp w=%0d t=%0t: got st=%0d strobes=%h op=%h run=%b ill=%b, expected st=%0d strobes=%h op=%h run=%b ill=%b",
                                 W, $time, state_dbg, strobes, op, run, illegal,
                                 cur.st, cur.mask, cur.op, cur.run, exp_ill);
                    end
                end
                if (state_dbg == S_RST) begin
                    started = 1'b0;
                end else if (state_dbg == S_T0) begin
                    if (started) begin
                        last_len = len; last_rd = rd; last_wr = wr;
                        last_add = add_cnt; last_ill = ill; last_mdrin = mdrin;
                    end
                    started = 1'b1;
                    len = 0; rd = 0; wr = 0; add_cnt = 0; ill = 0; mdrin = 0;
                end
                if (started) begin
                    len++;
                    rd      += int'(Read);
                    wr      += int'(Write);
                    add_cnt += int'(op == ALU_ADD);
                    ill     += int'(illegal);
                    mdrin   += int'(MDRin);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin : p_main
        logic [31:0] rnd;
        int          r;
        bit          found;

        clear = 1'b1;
        ir    = IR_LD;
        @(posedge clk);
        #1;
        clear = 1'b0;

        // reset state, then first fetch step
        @(negedge clk);
        check_eq("rst_state", int'(g_inst[0].state_dbg), 0);
        check_eq("rst_strobes", int'(g_inst[0].strobes), 0);
        check_eq("rst_run", int'(g_inst[0].run), 1);
        @(negedge clk);
        check_eq("t0_state", int'(g_inst[0].state_dbg), 1);
        check_eq("t0_strobes", int'(g_inst[0].strobes),
                 int'(M_PCOUT | M_MARIN | M_INCPC | M_ZHIGHIN | M_ZLOWIN));
        @(posedge clk);
        #1;

        // ld
        tick(30);
        check_eq("ld_len_w0", g_inst[0].last_len, 8);
        check_eq("ld_read_w0", g_inst[0].last_rd, 2);
        check_eq("ld_add_w0", g_inst[0].last_add, 1);
        check_eq("ld_len_w2", g_inst[1].last_len, 12);
        check_eq("ld_read_w2", g_inst[1].last_rd, 6);
        check_eq("ld_mdrin_w2", g_inst[1].last_mdrin, 6);
        check_eq("ld_write_w2", g_inst[1].last_wr, 0);

        // ldi
        ir = IR_LDI;
        do_clear();
        tick(30);
        check_eq("ldi_len_w0", g_inst[0].last_len, 6);
        check_eq("ldi_read_w0", g_inst[0].last_rd, 1);
        check_eq("ldi_len_w2", g_inst[1].last_len, 8);

        // st
        ir = IR_ST;
        do_clear();
        tick(30);
        check_eq("st_len_w0", g_inst[0].last_len, 8);
        check_eq("st_write_w0", g_inst[0].last_wr, 1);
        check_eq("st_read_w0", g_inst[0].last_rd, 1);
        check_eq("st_len_w2", g_inst[1].last_len, 12);
        check_eq("st_write_w2", g_inst[1].last_wr, 3);

        // unsupported opcode behaves as a 4-cycle NOP with one illegal pulse
        ir = IR_BAD;
        do_clear();
        tick(20);
        check_eq("bad_len_w0", g_inst[0].last_len, 4);
        check_eq("bad_ill_w0", g_inst[0].last_ill, 1);
        check_eq("bad_len_w2", g_inst[1].last_len, 6);

        // randomized: ir changes every cycle, occasional clear and halt
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom();
            r   = $urandom_range(0, 99);
            if (r < 2)       ir = IR_HALT;
            else if (r < 27) ir = {OP_LD, rnd[26:0]};
            else if (r < 52) ir = {OP_LDI, rnd[26:0]};
            else if (r < 77) ir = {OP_ST, rnd[26:0]};
            else             ir = rnd;
            clear = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        clear = 1'b0;

        // halt holds with everything idle, ir ignored
        ir = IR_HALT;
        do_clear();
        tick(15);
        ir = IR_LD;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    check_eq("halt_run_w0", int'(g_inst[0].run), 0);
                    check_eq("halt_strobes_w0", int'(g_inst[0].strobes), 0);
                end else begin
                    check_eq("halt_run_w2", int'(g_inst[1].run), 0);
                    check_eq("halt_state_w2", int'(g_inst[1].state_dbg), 9);
                end
            end
        end
        @(posedge clk);
        #1;

        // clear during the ld T6 wait
        ir = IR_LD;
        do_clear();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (g_inst[1].state_dbg == S_T6) found = 1'b1;
        end
        check_eq("reach_t6_w2", int'(found), 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check_eq("midclr_state_w2", int'(g_inst[1].state_dbg), 0);
        check_eq("midclr_strobes_w2", int'(g_inst[1].strobes), 0);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
